// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches the payload during Read, builds the
// start/data/parity/stop frame and shifts it out LSB-first during Transmit,
// holding the controller's shift input high until the last bit has finished.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           state,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 shift,
  output logic                 tx,
  output logic                 tx_done
);

  localparam int unsigned N  = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(N + 1);

  localparam logic [1:0]    ST_READ  = 2'b01;
  localparam logic [1:0]    ST_XMIT  = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [DATA_BITS-1:0] hold;
  logic [N-1:0]         sr;
  logic [N-1:0]         frame;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 fin;
  logic                 parity;
  logic                 active;
  logic                 bit_end;
  logic                 last_bit_end;

  assign active       = (state == ST_XMIT) && !fin;
  assign bit_end      = (cnt == CNT_LAST);
  assign last_bit_end = active && bit_end && (idx == IDX_LAST);
  assign parity       = (^hold) ^ (PARITY_ODD != 0);

  // Payload latch: follows data_in only while the controller is in Read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (state == ST_READ) begin
      hold <= data_in;
    end
  end

  // Frame image: start bit at LSB, payload, optional parity, stop bits as ones.
  always_comb begin
    frame              = '1;
    frame[0]           = 1'b0;
    frame[DATA_BITS:1] = hold;
    if (PARITY_EN != 0) begin
      frame[DATA_BITS+1] = parity;
    end
  end

  // Baud timing and shifter: preload outside Transmit, shift once per bit time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '1;
      cnt <= '0;
      idx <= '0;
      fin <= 1'b0;
    end else if (state != ST_XMIT) begin
      sr  <= frame;
      cnt <= '0;
      idx <= '0;
      fin <= 1'b0;
    end else if (!fin) begin
      if (bit_end) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          fin <= 1'b1;
        end else begin
          sr  <= {1'b1, sr[N-1:1]};
          idx <= idx + IW'(1);
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Completion pulse: high in the first cycle fin is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_done <= 1'b0;
    end else begin
      tx_done <= last_bit_end;
    end
  end

  // Line and handshake outputs; reset forces idle immediately.
  assign shift = rst && active;
  assign tx    = shift ? sr[0] : 1'b1;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (8E1, 8O1, 8N2, all N=11)
// share one stimulus stream and are checked every cycle against a frame model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam int NB  = 11;
  localparam int NC  = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state = 2'b11;
  logic [7:0] data_in = 8'h3C;
  logic [2:0] tx_v;
  logic [2:0] sh_v;
  logic [2:0] dn_v;

  // Per-instance configuration as seen by the model.
  bit pe [3] = '{1'b1, 1'b1, 1'b0};
  bit po [3] = '{1'b0, 1'b1, 1'b0};

  int n_pass  = 0;
  int n_total = 0;

  // Model state: cycles in Transmit, held byte, byte latched into the frame.
  int          t = 0;
  logic [7:0]  m_hold = 8'h00;
  logic [7:0]  m_frame = 8'h00;
  logic [NB-1:0] rec [3];
  int          sh_cnt [3];
  int          done_cnt [3];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in),
    .shift(sh_v[0]), .tx(tx_v[0]), .tx_done(dn_v[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in),
    .shift(sh_v[1]), .tx(tx_v[1]), .tx_done(dn_v[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                       .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in),
    .shift(sh_v[2]), .tx(tx_v[2]), .tx_done(dn_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Line level of frame bit k: start 0, data LSB-first, parity, then stop ones.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input bit p_en, input bit p_odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (p_en && k == 9) return (^d) ^ p_odd;
    return 1'b1;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin : chk
    int   pt;
    logic e_sh;
    logic e_tx;
    logic e_dn;
    pt = t;
    if (!rst) t = 0;
    else if (state == 2'b11) t = t + 1;
    else t = 0;
    for (int i = 0; i < 3; i++) begin
      e_sh = (t >= 1) && (t <= NC);
      e_tx = e_sh ? exp_bit(m_frame, (t - 1) / CPB, pe[i], po[i]) : 1'b1;
      e_dn = rst && (pt == NC) && (t == NC + 1);
      if (t == 1) begin
        sh_cnt[i]   = 0;
        done_cnt[i] = 0;
        rec[i]      = '0;
      end
      sh_cnt[i]   = sh_cnt[i] + int'(sh_v[i]);
      done_cnt[i] = done_cnt[i] + int'(dn_v[i]);
      if (e_sh && ((t - 1) % CPB) == 1) rec[i][(t - 1) / CPB] = tx_v[i];
      check($sformatf("shift[%0d] t=%0d", i, t), 32'(sh_v[i]), 32'(e_sh));
      check($sformatf("tx[%0d] t=%0d", i, t), 32'(tx_v[i]), 32'(e_tx));
      check($sformatf("tx_done[%0d] t=%0d", i, t), 32'(dn_v[i]), 32'(e_dn));
    end
    if (!rst) begin
      m_hold  = 8'h00;
      m_frame = 8'h00;
    end else if (state != 2'b11) begin
      m_frame = m_hold;
      if (state == 2'b01) m_hold = data_in;
    end
  end

  // Drive state/data for n cycles, starting just after a rising edge.
  task automatic cyc(input logic [1:0] s, input logic [7:0] d, input int n);
    state   = s;
    data_in = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rec[i] = '0; sh_cnt[i] = 0; done_cnt[i] = 0;
    end
    @(posedge clk); #1;
    // Reset with Transmit and junk data on the inputs.
    for (int c = 0; c < 3; c++) begin
      check("rst_tx", 32'(tx_v), 32'h7);
      check("rst_shift", 32'(sh_v), 32'h0);
      check("rst_done", 32'(dn_v), 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b1;

    // No Read after reset: frame carries hold = 0x00.
    cyc(2'b00, 8'hEE, 1);
    cyc(2'b10, 8'hEE, 1);
    cyc(2'b11, 8'hEE, NC + 3);
    check("hold0_e1_line", 32'(rec[0]), 32'h400);
    check("odd_parity_00", 32'(rec[1][9]), 32'h1);

    // 0xA5 on 8E1, then stay in Transmit 20 cycles past completion.
    cyc(2'b01, 8'hA5, 1);
    cyc(2'b10, 8'hA5, 1);
    cyc(2'b11, 8'hA5, NC + 21);
    check("a5_e1_line", 32'(rec[0]), 32'h54A);
    check("a5_shift_cycles", 32'(sh_cnt[0]), 32'd44);
    check("a5_done_pulses", 32'(done_cnt[0]), 32'd1);
    check("a5_o1_parity", 32'(rec[1][9]), 32'h1);

    // 0xFF on 8N2: start then ten ones.
    cyc(2'b01, 8'hFF, 1);
    cyc(2'b10, 8'hFF, 1);
    cyc(2'b11, 8'hFF, NC + 2);
    check("ff_n2_line", 32'(rec[2]), 32'h7FE);
    check("ff_n2_shift_cycles", 32'(sh_cnt[2]), 32'd44);

    // Abort at cycle 10, then a clean restart of the same byte.
    cyc(2'b01, 8'h5A, 1);
    cyc(2'b10, 8'h5A, 1);
    cyc(2'b11, 8'h5A, 9);
    state = 2'b00;
    #1;
    check("abort_tx", 32'(tx_v), 32'h7);
    check("abort_shift", 32'(sh_v), 32'h0);
    @(posedge clk); #1;
    cyc(2'b00, 8'h5A, 2);
    check("abort_no_done", 32'(done_cnt[0]), 32'd0);
    cyc(2'b10, 8'h5A, 1);
    cyc(2'b11, 8'h5A, NC + 2);
    check("restart_5a_line", 32'(rec[0]), 32'h4B4);
    check("restart_shift_cycles", 32'(sh_cnt[0]), 32'd44);
    check("restart_done_pulses", 32'(done_cnt[0]), 32'd1);

    // Asynchronous reset in cycle 20 of a frame; next frame skips Read.
    cyc(2'b01, 8'h33, 1);
    cyc(2'b10, 8'h33, 1);
    state = 2'b11;
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_tx", 32'(tx_v), 32'h7);
    check("midrst_shift", 32'(sh_v), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    state = 2'b00;
    rst   = 1'b1;
    cyc(2'b00, 8'h77, 1);
    cyc(2'b10, 8'h77, 1);
    cyc(2'b11, 8'h77, NC + 2);
    check("post_rst_line", 32'(rec[0]), 32'h400);
    check("post_rst_done", 32'(done_cnt[0]), 32'd1);

    cyc(2'b00, 8'h00, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit datapath stage directly downstream of the TX control FSM. Latches the parallel byte while the FSM is in Read and builds the start/data/parity/stop frame. Shifts the frame out LSB-first at the baud rate while the FSM is in Transmit, and drives the FSM's `shift` input high until the frame is complete, so the FSM returns to Idle.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal ≥ 2
- `DATA_BITS`, 8, payload width; legal 5–9
- `PARITY_EN`, 1, 1 = append parity bit after data
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (ignored when `PARITY_EN`=0)
- `STOP_BITS`, 1, number of stop bits; legal 1 or 2
- `clk`  input  1  single system clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset (low = reset)
- `state`  input  2  controller state: 00 Idle, 01 Read, 10 Request, 11 Transmit
- `data_in`  input  DATA_BITS  parallel byte to send
- `shift`  output  1  to controller; high while frame bits remain in Transmit
- `tx`  output  1  serial line, idle high
- `tx_done`  output  1  one-cycle pulse on frame completion

## Operation
- Frame length N = 1 + DATA_BITS + PARITY_EN + STOP_BITS. Order: start (0), data bit 0…DATA_BITS-1, parity, stop bit(s) (1).
- Parity: even = XOR of `hold`; odd = inverted XOR.
- `hold` register: loads `data_in` on every clock with `state`=01. It holds in all other states. An Idle→Request path with no Read sends the last held value.
- When `state`≠11 on a clock edge, the block does the following:
  - loads frame register `sr` (N bits) from `hold` with the start bit at `sr[0]`
  - clears baud counter `cnt` (width $clog2(CLKS_PER_BIT)) and bit index `idx` (width $clog2(N+1))
  - clears `fin`
- When `state`=11 and `fin`=0, the block does the following:
  - `cnt` increments each cycle
  - at `cnt`=CLKS_PER_BIT-1, `cnt` returns to 0, `sr` shifts right with 1 filled in, and `idx` increments
  - at `cnt`=CLKS_PER_BIT-1 with `idx`=N-1, `fin` is set instead of shifting
- `shift` = (`state`=11) & ~`fin`. This is combinational from registered signals.
- `tx` = `shift` ? `sr[0]` : 1.
- `tx_done`: registered. It is high for exactly the first cycle in which `fin`=1.
- After `fin` sets, the state is held: `shift`=0 and `tx`=1 while `state` stays 11. There is no retransmit until `state` leaves 11.
- Abort: if `state` leaves 11 before `fin`, the following happens:
  - `tx` goes to 1 and `shift` goes to 0 in the same cycle
  - counters clear on the next edge
  - no `tx_done` is issued
- CTS changes mid-frame are not visible to this block. A frame that has started always completes unless aborted.

## Timing
- Reset values: `hold`=0, `sr`=all 1, `cnt`=0, `idx`=0, `fin`=0, `tx_done`=0. Outputs are `tx`=1 and `shift`=0. Outputs take these values immediately on `rst` low, independent of `clk`.
- Call the first cycle with `state`=11 cycle 1. `tx`=start bit for cycles 1…CLKS_PER_BIT. Bit k occupies cycles k·CLKS_PER_BIT+1 … (k+1)·CLKS_PER_BIT.
- `shift`=1 for exactly N·CLKS_PER_BIT cycles and drops in cycle N·CLKS_PER_BIT+1. `tx_done`=1 in that same cycle. The controller samples `shift`=0 and enters Idle on the following edge.
- `shift` is already 1 in cycle 1, so the controller never sees a spurious 0 on Transmit entry.
- Reset deassertion: normal operation resumes on the first rising edge after `rst` returns high.

## Test plan
1. `rst`=0 for 3 cycles, with `state` and `data_in` at arbitrary values → `tx`=1, `shift`=0, `tx_done`=0 throughout. After release, `hold`=0.
2. CLKS_PER_BIT=4, 8E1. Drive `data_in`=0xA5 with `state`=01, then 10, then 11 → `tx` bits are 0,1,0,1,0,0,1,0,1,0(parity),1. Each bit lasts 4 cycles. `shift` is high for 44 cycles, then `shift`=0 and `tx_done`=1 in cycle 45.
3. PARITY_ODD=1, `data_in`=0x00 → parity bit = 1. With PARITY_EN=0 and STOP_BITS=2, `data_in`=0xFF → N=11, line is 0 followed by ten 1s, and `shift` is high for 44 cycles.
4. Abort: `state` goes 11→00 at cycle 10 of a frame → `tx`=1 and `shift`=0 in cycle 10, no `tx_done`. The next entry to 11 restarts with a full 4-cycle start bit.
5. `state` held at 11 after completion for 20 cycles → `shift` stays 0, `tx` stays 1, `tx_done` pulses exactly once.
6. `rst` pulled low asynchronously mid-edge at cycle 20 of a frame → `tx`=1 and `shift`=0 immediately, `hold`=0. The next frame after reset sends 0x00 if Read is skipped.
